// File: rtl/uart_flow_ctrl.sv
// uart_flow_ctrl: XON/XOFF software flow control injected into the UART
// transmit byte stream, driven by the occupancy of the receive buffer.
// Control bytes win over data for the single output register; data bytes
// are forwarded unmodified with one cycle of latency.
module uart_flow_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    DEPTH      = 4096,
    parameter int                    XOFF_LEVEL = 3072,
    parameter int                    XON_LEVEL  = 1024,
    parameter logic [DATA_WIDTH-1:0] XOFF_CHAR  = 8'h13,
    parameter logic [DATA_WIDTH-1:0] XON_CHAR   = 8'h11
) (
    input  logic                       clk,
    input  logic                       arstn,
    input  logic                       enable,
    input  logic [$clog2(DEPTH):0]     fifo_level,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       paused,
    output logic [15:0]                xoff_count
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] XOFF_LVL = LW'(XOFF_LEVEL);
    localparam logic [LW-1:0] XON_LVL  = LW'(XON_LEVEL);

    // Threshold ordering must leave a hysteresis band inside the buffer.
    generate
        if (!(XON_LEVEL < XOFF_LEVEL && XOFF_LEVEL <= DEPTH)) begin : g_bad_levels
            $error("uart_flow_ctrl: need XON_LEVEL < XOFF_LEVEL <= DEPTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SEND_XOFF = 2'd1,
        PAUSED    = 2'd2,
        SEND_XON  = 2'd3
    } state_t;

    state_t state;
    logic   run_ok;      // low during reset and until the first edge after release
    logic   out_free;
    logic   data_state;

    assign out_free   = !m_axis_tvalid || m_axis_tready;
    assign data_state = (state == RUN) || (state == PAUSED);

    // Upstream may only hand over a byte when no control byte is waiting
    // and the output register can take it this cycle.
    assign s_axis_tready = run_ok && data_state && out_free;

    // Flow-control FSM together with the output register and XOFF counter.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state         <= RUN;
            run_ok        <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            paused        <= 1'b0;
            xoff_count    <= '0;
        end else begin
            run_ok <= 1'b1;

            // Output register: a presented byte is only replaced once free.
            if (out_free) begin
                if (!data_state) begin
                    m_axis_tdata  <= (state == SEND_XOFF) ? XOFF_CHAR : XON_CHAR;
                    m_axis_tvalid <= 1'b1;
                end else if (s_axis_tvalid && s_axis_tready) begin
                    m_axis_tdata  <= s_axis_tdata;
                    m_axis_tvalid <= 1'b1;
                end else begin
                    m_axis_tvalid <= 1'b0;
                end
            end

            case (state)
                RUN: begin
                    if (enable && fifo_level >= XOFF_LVL)
                        state <= SEND_XOFF;
                end
                SEND_XOFF: begin
                    if (out_free) begin
                        state  <= PAUSED;
                        paused <= 1'b1;
                        if (xoff_count != 16'hFFFF)
                            xoff_count <= xoff_count + 16'd1;
                    end
                end
                PAUSED: begin
                    // No repeat XOFF here; only a resume condition leaves.
                    if (fifo_level <= XON_LVL || !enable)
                        state <= SEND_XON;
                end
                SEND_XON: begin
                    if (out_free) begin
                        state  <= RUN;
                        paused <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_flow_ctrl.sv
// tb_uart_flow_ctrl: vector table for the directed flow, hand-written
// sequences for the multi-cycle corners, then randomized traffic checked
// against a queue-based reference model of the flow-control rules.
module tb_uart_flow_ctrl;

    localparam logic [7:0] XOFF = 8'h13;
    localparam logic [7:0] XON  = 8'h11;

    logic        clk = 1'b0;
    logic        arstn;
    logic        enable;
    logic [12:0] fifo_level;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        paused;
    logic [15:0] xoff_count;

    int vecs = 0;
    int errs = 0;

    uart_flow_ctrl dut (
        .clk           (clk),
        .arstn         (arstn),
        .enable        (enable),
        .fifo_level    (fifo_level),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .paused        (paused),
        .xoff_count    (xoff_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [12:0] lvl;
        logic        sv;
        logic [7:0]  sd;
        logic        mr;
        logic        srdy;   // expected s_tready before the edge
        logic        mv;     // expected outputs after the edge
        logic [7:0]  md;
        logic        pa;
        logic [15:0] cnt;
    } vec_t;

    vec_t rows[$];

    task automatic add(input int en, input int lvl, input int sv, input int sd, input int mr,
                       input int srdy, input int mv, input int md, input int pa, input int cnt);
        vec_t r;
        r.en = 1'(en); r.lvl = 13'(lvl); r.sv = 1'(sv); r.sd = 8'(sd); r.mr = 1'(mr);
        r.srdy = 1'(srdy); r.mv = 1'(mv); r.md = 8'(md); r.pa = 1'(pa); r.cnt = 16'(cnt);
        rows.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: output slot, one pending control byte, host-held flag.
    bit          m_ov, m_pa, m_rok, pend_v;
    logic [7:0]  m_od, pend_b;
    logic [15:0] m_cnt;

    function automatic bit model_srdy();
        return m_rok && (!m_ov || m_tready) && !pend_v;
    endfunction

    task automatic model_reset();
        m_ov = 0; m_pa = 0; m_rok = 0; pend_v = 0; m_od = 8'h00; pend_b = 8'h00; m_cnt = 16'h0;
    endtask

    task automatic model_step();
        bit free, idle, held, rdy;
        free = !m_ov || m_tready;
        idle = !pend_v;
        held = m_pa;
        rdy  = model_srdy();
        if (free) begin
            if (pend_v) begin
                m_ov = 1; m_od = pend_b; pend_v = 0;
                if (pend_b == XOFF) begin
                    m_pa = 1;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                end else begin
                    m_pa = 0;
                end
            end else if (rdy && s_tvalid) begin
                m_ov = 1; m_od = s_tdata;
            end else begin
                m_ov = 0;
            end
        end
        if (idle) begin
            if (!held && enable && fifo_level >= 13'd3072) begin
                pend_v = 1; pend_b = XOFF;
            end else if (held && (fifo_level <= 13'd1024 || !enable)) begin
                pend_v = 1; pend_b = XON;
            end
        end
        m_rok = 1;
    endtask

    initial begin
        int acc, n11, n13, nother;
        bit seen;

        arstn = 1'b0; enable = 1'b1; fifo_level = 13'd3071;
        s_tdata = 8'h00; s_tvalid = 1'b0; m_tready = 1'b1;

        // ---------------- vector table ----------------
        add(1,3071,1,8'h00,1, 0, 0,8'h00,0,0);           // first cycle after release
        for (int i = 0; i < 16; i++)
            add(1,3071,1,i,1, 1, 1,i,0,0);                  // 0x00..0x0F stream
        add(1,3071,1,8'hA5,1, 1, 1,8'hA5,0,0);
        add(1,3072,0,8'h00,0, 0, 1,8'hA5,0,0);            // stall, cross XOFF
        add(1,3072,0,8'h00,0, 0, 1,8'hA5,0,0);            // still held
        add(1,3072,0,8'h00,1, 0, 1,XOFF,1,1);             // XOFF after A5
        add(1,2000,0,8'h00,1, 1, 0,XOFF,1,1);             // no output at 2000
        add(1,1024,0,8'h00,1, 1, 0,XOFF,1,1);             // -> SEND_XON
        add(1,1024,0,8'h00,1, 0, 1,XON,0,1);              // XON
        add(1,1024,0,8'h00,1, 1, 0,XON,0,1);
        add(1,4000,0,8'h00,1, 1, 0,XON,0,1);              // -> SEND_XOFF
        add(1,4000,0,8'h00,1, 0, 1,XOFF,1,2);
        add(0,4000,0,8'h00,1, 1, 0,XOFF,1,2);             // enable drop resumes
        add(0,4000,0,8'h00,1, 0, 1,XON,0,2);
        add(0,4000,1,8'h42,1, 1, 1,8'h42,0,2);            // no XOFF with enable=0
        add(0,4000,0,8'h00,1, 1, 0,8'h42,0,2);

        #3;
        chk("rst_srdy", 32'(s_tready), 32'd0);
        chk("rst_mv", 32'(m_tvalid), 32'd0);
        chk("rst_md", 32'(m_tdata), 32'd0);
        chk("rst_paused", 32'(paused), 32'd0);
        chk("rst_cnt", 32'(xoff_count), 32'd0);

        @(negedge clk);
        arstn = 1'b1;
        foreach (rows[i]) begin
            enable = rows[i].en; fifo_level = rows[i].lvl; s_tvalid = rows[i].sv;
            s_tdata = rows[i].sd; m_tready = rows[i].mr;
            #1;
            chk($sformatf("row%0d_srdy", i), 32'(s_tready), 32'(rows[i].srdy));
            @(negedge clk);
            chk($sformatf("row%0d_mv", i), 32'(m_tvalid), 32'(rows[i].mv));
            chk($sformatf("row%0d_md", i), 32'(m_tdata), 32'(rows[i].md));
            chk($sformatf("row%0d_paused", i), 32'(paused), 32'(rows[i].pa));
            chk($sformatf("row%0d_cnt", i), 32'(xoff_count), 32'(rows[i].cnt));
        end

        // ---------------- continuous 0x13 data across XOFF/XON ----------------
        acc = 0; n11 = 0; n13 = 0; nother = 0;
        for (int c = 0; c < 40; c++) begin
            enable = 1'b1; fifo_level = (c >= 5 && c < 15) ? 13'd3072 : 13'd0;
            s_tvalid = (c < 30); s_tdata = 8'h13; m_tready = 1'b1;
            #1;
            if (s_tvalid && s_tready) acc++;
            if (m_tvalid && m_tready) begin
                if (m_tdata == 8'h13) n13++;
                else if (m_tdata == 8'h11) n11++;
                else nother++;
            end
            if (c == 12) chk("cross_paused", 32'(paused), 32'd1);
            @(negedge clk);
        end
        chk("cross_data_plus_xoff", 32'(n13), 32'(acc + 1));
        chk("cross_xon_once", 32'(n11), 32'd1);
        chk("cross_no_other", 32'(nother), 32'd0);
        chk("cross_cnt", 32'(xoff_count), 32'd3);
        chk("cross_resumed", 32'(paused), 32'd0);

        // ---------------- reset while XOFF is pending behind a stall ----------------
        enable = 1'b1; fifo_level = 13'd0; s_tvalid = 1'b1; s_tdata = 8'hA5; m_tready = 1'b0;
        @(negedge clk);
        fifo_level = 13'd3072; s_tvalid = 1'b0;
        @(negedge clk);
        chk("rst2_held_mv", 32'(m_tvalid), 32'd1);
        chk("rst2_held_md", 32'(m_tdata), 32'hA5);
        #2 arstn = 1'b0;
        #1;
        chk("rst2_mv", 32'(m_tvalid), 32'd0);
        chk("rst2_srdy", 32'(s_tready), 32'd0);
        chk("rst2_paused", 32'(paused), 32'd0);
        chk("rst2_cnt", 32'(xoff_count), 32'd0);
        @(negedge clk);
        fifo_level = 13'd0; m_tready = 1'b1; arstn = 1'b1;
        #1;
        chk("rst2_srdy_before_edge", 32'(s_tready), 32'd0);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) chk("rst2_srdy_after_edge", 32'(s_tready), 32'd1);
            if (m_tvalid) seen = 1;
        end
        chk("rst2_no_emission", 32'(seen), 32'd0);

        // ---------------- randomized traffic vs reference model ----------------
        arstn = 1'b0; s_tvalid = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        arstn = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            enable = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 9) < 2) begin
                case ($urandom_range(0, 3))
                    0: fifo_level = 13'($urandom_range(0, 1024));
                    1: fifo_level = 13'($urandom_range(1025, 3071));
                    2: fifo_level = 13'($urandom_range(3072, 4096));
                    default: fifo_level = 13'(1023 + $urandom_range(0, 2) + 2048 * $urandom_range(0, 1));
                endcase
            end
            s_tvalid = ($urandom_range(0, 99) < 60);
            case ($urandom_range(0, 3))
                0: s_tdata = XOFF;
                1: s_tdata = XON;
                default: s_tdata = 8'($urandom);
            endcase
            m_tready = ($urandom_range(0, 99) < 70);
            #1;
            chk("rnd_srdy", 32'(s_tready), 32'(model_srdy()));
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk("rnd_mv", 32'(m_tvalid), 32'(m_ov));
            chk("rnd_md", 32'(m_tdata), 32'(m_od));
            chk("rnd_paused", 32'(paused), 32'(m_pa));
            chk("rnd_cnt", 32'(xoff_count), 32'(m_cnt));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
